// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master blocks (ADC reader, DAC writer):
// FSM state encodings, default timing constants and a sizing helper.
package spi_pkg;

    // Default timing, in fpga_clock cycles
    localparam int SPI_CLK_DIV   = 22;  // SCLK half-period (88.67 MHz / 44 ~= 2.0 MHz)
    localparam int SPI_DATA_BITS = 16;
    localparam int SPI_CS_SETUP  = 4;   // CS low to first SCLK rise
    localparam int SPI_CS_HOLD   = 4;   // last SCLK fall to CS high
    localparam int SPI_CS_GAP    = 8;   // minimum CS-high time between frames

    // FSM state encodings
    typedef logic [2:0] spi_state_t;
    localparam spi_state_t ST_IDLE    = 3'd0;
    localparam spi_state_t ST_SETUP   = 3'd1;
    localparam spi_state_t ST_SCLK_LO = 3'd2;
    localparam spi_state_t ST_SCLK_HI = 3'd3;
    localparam spi_state_t ST_HOLD    = 3'd4;
    localparam spi_state_t ST_GAP     = 3'd5;

    // Largest of four durations; sizes the shared phase counter
    function automatic int spi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous input, async active-high reset.
module spi_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is used downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adc_spi_master_in.sv
// SPI mode-0 master receiver: on start, runs one CS frame of DATA_BITS SCLK
// cycles, samples MISO MSB first and presents the word with a one-cycle strobe.
module adc_spi_master_in
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = SPI_CLK_DIV,
    parameter int DATA_BITS = SPI_DATA_BITS,
    parameter int CS_SETUP  = SPI_CS_SETUP,
    parameter int CS_HOLD   = SPI_CS_HOLD,
    parameter int CS_GAP    = SPI_CS_GAP
) (
    input  logic                 fpga_clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 spi_data_in,
    output logic                 spi_cs_out,
    output logic                 spi_clock_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy
);

    // One phase counter serves SETUP, both SCLK halves, HOLD and GAP
    localparam int CNT_W = $clog2(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(DATA_BITS);

    spi_state_t           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 cs_q,      cs_d;
    logic                 sclk_q,    sclk_d;
    logic                 busy_q,    busy_d;
    logic                 miso_sync;

    spi_sync2 u_miso_sync (
        .clk (fpga_clock),
        .rst (rst),
        .d   (spi_data_in),
        .q   (miso_sync)
    );

    // Next-state logic; outputs are derived from the next state so they are all registered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SCLK_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCLK_HI: begin
                // Sample at the end of the high phase: the synchroniser delay is
                // absorbed and the slave has not yet moved to the next bit
                if (cnt_q == DIV_LAST) begin
                    shift_d   = (shift_q << 1) | DATA_BITS'(miso_sync);
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    state_d   = ST_SCLK_LO;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCLK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = (bit_cnt_q == BITS_ALL) ? ST_HOLD : ST_SCLK_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_d   = !(state_d inside {ST_SETUP, ST_SCLK_HI, ST_SCLK_LO, ST_HOLD});
        sclk_d = (state_d == ST_SCLK_HI);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces CS high and SCLK low immediately
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
        end
    end

    assign spi_cs_out    = cs_q;
    assign spi_clock_out = sclk_q;
    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_adc_spi_master_in.sv
// Bench for adc_spi_master_in with a behavioural mode-0 ADC and a word scoreboard.
module tb_adc_spi_master_in;

    localparam int CD = 2;
    localparam int DB = 16;
    localparam int SU = 2;
    localparam int HO = 2;
    localparam int GP = 3;
    localparam int VALID_CYC = 1 + SU + 2 * CD * DB + HO;  // 69

    logic          fpga_clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          spi_data_in = 1'b0;
    logic          spi_cs_out;
    logic          spi_clock_out;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DB-1:0] exp_q[$];   // words the DUT must deliver, in order
    logic [DB-1:0] adc_q[$];   // words the ADC model serves, one per CS frame
    logic [DB-1:0] adc_sh = '0;
    int            valid_cnt = 0;
    int            rise_cnt = 0;
    logic          mon_en = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DB-1:0] prev_data = '0;

    adc_spi_master_in #(
        .CLK_DIV   (CD),
        .DATA_BITS (DB),
        .CS_SETUP  (SU),
        .CS_HOLD   (HO),
        .CS_GAP    (GP)
    ) dut (
        .fpga_clock    (fpga_clock),
        .rst           (rst),
        .start         (start),
        .spi_data_in   (spi_data_in),
        .spi_cs_out    (spi_cs_out),
        .spi_clock_out (spi_clock_out),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    always #5 fpga_clock = ~fpga_clock;

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- ADC model (mode 0, MSB valid at CS fall) ----------------
    always @(negedge spi_cs_out) begin
        if (adc_q.size() > 0) adc_sh = adc_q.pop_front();
        else                  adc_sh = '0;
        spi_data_in = adc_sh[DB-1];
    end

    always @(negedge spi_clock_out) begin
        if (spi_cs_out === 1'b0) begin
            adc_sh = adc_sh << 1;
            spi_data_in = adc_sh[DB-1];
        end
    end

    always @(posedge spi_clock_out) rise_cnt++;

    // ---------------- scoreboard and protocol monitor ----------------
    always @(negedge fpga_clock) begin
        if (mon_en) begin
            if (spi_cs_out === 1'b1) check("sclk_low_while_cs_high", spi_clock_out, 1'b0);
            check("valid_single_cycle", data_valid & prev_valid, 1'b0);
            if (data_valid !== 1'b1 && !rst) check("data_out_stable", data_out, prev_data);
            if (data_valid === 1'b1) begin
                valid_cnt++;
                check("strobe_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("data_out_word", data_out, exp_q.pop_front());
            end
        end
        prev_valid = data_valid;
        prev_data  = data_out;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge fpga_clock);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    // One start pulse; checks CS timing, strobe cycle and SCLK edge count
    task automatic run_frame(input logic [DB-1:0] word);
        int n;
        int r0;
        adc_q.push_back(word);
        exp_q.push_back(word);
        r0 = rise_cnt;
        @(negedge fpga_clock) start = 1'b1;
        @(negedge fpga_clock) start = 1'b0;
        n = 1;
        check("cs_low_cycle1", spi_cs_out, 1'b0);
        check("busy_cycle1", busy, 1'b1);
        while (data_valid !== 1'b1 && n < 300) begin
            @(negedge fpga_clock);
            n++;
        end
        check("valid_cycle", n, VALID_CYC);
        check("cs_high_at_valid", spi_cs_out, 1'b1);
        check("sclk_rising_edges", rise_cnt - r0, DB);
        wait_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int v0;
        int gap;

        // Reset state
        repeat (3) @(negedge fpga_clock);
        check("rst_cs", spi_cs_out, 1'b1);
        check("rst_sclk", spi_clock_out, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge fpga_clock);

        // Single frame
        run_frame(16'hA5C3);
        check("data_hold_after_frame", data_out, 16'hA5C3);

        // Back-to-back frames with start held high
        adc_q.push_back(16'hFFFF); exp_q.push_back(16'hFFFF);
        adc_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        v0 = valid_cnt;
        gap = 0;
        @(negedge fpga_clock) start = 1'b1;
        n = 0;
        while (n < 150) begin
            @(negedge fpga_clock);
            n++;
            if (n == 100) start = 1'b0;
            if (valid_cnt - v0 == 1 && spi_cs_out === 1'b1) gap++;
        end
        start = 1'b0;
        check("two_strobes_by_150", valid_cnt - v0, 2);
        check("cs_gap_min", gap >= GP, 1'b1);
        wait_idle();
        repeat (20) @(negedge fpga_clock);
        check("no_third_frame", valid_cnt - v0, 2);
        check("scoreboard_drained", exp_q.size(), 0);

        // Start pulses while busy are ignored
        adc_q.push_back(16'h3C5A); exp_q.push_back(16'h3C5A);
        v0 = valid_cnt;
        @(negedge fpga_clock) start = 1'b1;
        @(negedge fpga_clock) start = 1'b0;
        n = 1;
        while (data_valid !== 1'b1 && n < 300) begin
            start = (n == 10 || n == 30 || n == 60);
            check("busy_during_frame", busy, 1'b1);
            @(negedge fpga_clock);
            n++;
        end
        start = 1'b0;
        check("valid_cycle_with_extra_starts", n, VALID_CYC);
        wait_idle();
        repeat (10) @(negedge fpga_clock);
        check("single_strobe", valid_cnt - v0, 1);
        check("no_queued_frame", adc_q.size(), 0);

        // Reset mid-frame
        rst = 1'b1;
        repeat (2) @(negedge fpga_clock);
        rst = 1'b0;
        repeat (2) @(negedge fpga_clock);
        adc_q.push_back(16'h1234);
        v0 = valid_cnt;
        @(negedge fpga_clock) start = 1'b1;
        @(negedge fpga_clock) start = 1'b0;
        n = 1;
        while (n < 40) begin
            @(negedge fpga_clock);
            n++;
        end
        check("pre_rst_cs_low", spi_cs_out, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_cs", spi_cs_out, 1'b1);
        check("midrst_sclk", spi_clock_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data_out", data_out, 16'h0000);
        check("midrst_valid", data_valid, 1'b0);
        repeat (2) @(negedge fpga_clock);
        rst = 1'b0;
        repeat (80) @(negedge fpga_clock);
        check("no_strobe_after_rst", valid_cnt - v0, 0);
        check("data_out_after_rst", data_out, 16'h0000);
        run_frame(16'hA5C3);
        check("final_data_out", data_out, 16'hA5C3);
        check("final_scoreboard", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_master_in.md
Name: adc_spi_master_in

Overview:
- SPI master receiver: reads one DATA_BITS-wide sample from an external serial ADC per `start` request.
- Runs on fpga_clock (88.67 MHz) and generates its own CS and SCLK.
- Read-direction counterpart of the DAC SPI writer. Feeds `frequency` / sample logic in top with `data_out` plus a one-cycle `data_valid` strobe.
- SPI mode 0: SCLK idles low, data MSB first, slave shifts on falling edge.

Parameters:
- CLK_DIV, 22: fpga_clock cycles per SCLK half-period (88.67 MHz / 44 ≈ 2.0 MHz SCLK); legal range 2..255.
- DATA_BITS, 16: bits per frame; legal range 1..32.
- CS_SETUP, 4: cycles from CS low to first SCLK rising edge.
- CS_HOLD, 4: cycles from last SCLK falling edge to CS high.
- CS_GAP, 8: minimum CS-high cycles between frames.

Ports:
- fpga_clock  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one frame; level-sampled in IDLE only.
- spi_data_in  in  1  MISO from ADC, asynchronous to fpga_clock.
- spi_cs_out  out  1  chip select, active low.
- spi_clock_out  out  1  SCLK.
- data_out  out  DATA_BITS  last completed sample.
- data_valid  out  1  one-cycle strobe; data_out updated in the same cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, all outputs registered):
  - spi_cs_out=1, spi_clock_out=0, data_out=0, data_valid=0, busy=0, state=IDLE, all counters 0.
- MISO synchroniser: 2-flop on spi_data_in, reset to 0.
- FSM states: IDLE, SETUP, SCLK_LO, SCLK_HI, HOLD, GAP.
- IDLE:
  - start=1 -> SETUP; spi_cs_out=0 and busy=1 from the next cycle.
- SETUP:
  - Counts CS_SETUP cycles, then -> SCLK_HI with spi_clock_out=1 (first rising edge).
- SCLK_HI:
  - Lasts CLK_DIV cycles.
  - On its last cycle, shift the synchronised MISO into shift_reg LSB; bit_cnt+1.
  - Sampling late in the high phase absorbs the 2-cycle synchroniser delay and stays ahead of the slave's next falling-edge update.
  - Then spi_clock_out=0 -> SCLK_LO.
- SCLK_LO:
  - Lasts CLK_DIV cycles.
  - If bit_cnt==DATA_BITS -> HOLD; else spi_clock_out=1 -> SCLK_HI.
- HOLD:
  - Counts CS_HOLD cycles.
  - Then spi_cs_out=1, data_out<=shift_reg, data_valid=1 for exactly one cycle -> GAP.
- GAP:
  - Counts CS_GAP cycles with CS high, then -> IDLE (busy=0).
  - A start held high across GAP launches the next frame on the first IDLE cycle.
- Frame length: exactly DATA_BITS SCLK rising edges and DATA_BITS falling edges; SCLK is never high while CS is high.
- Latency, start sampled at cycle 0:
  - CS low at cycle 1.
  - data_valid at cycle 1+CS_SETUP+2*CLK_DIV*DATA_BITS+CS_HOLD.
  - Defaults give 1+4+704+4 = cycle 713.
- start while busy: ignored, not queued.
- data_out: holds its value between frames; changes only coincident with data_valid.
- rst mid-frame:
  - Immediate return to reset values; CS rises and SCLK falls asynchronously.
  - No data_valid; partial shift_reg discarded.
- Counters: half-period counter ceil(log2(CLK_DIV+1)) bits; bit_cnt ceil(log2(DATA_BITS+1)) bits; no wrap inside a frame.

Decomposition:
- Shared package spi_pkg:
  - state enum for this FSM.
  - Default timing constants CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP.
  - Also reused by the DAC writer.
- One natural sub-module: spi_sync2, the 2-flop synchroniser with async reset, reusable for the slave-side inputs.
- Counters and FSM stay in this module.

Test Plan:
- Bench parameters: CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=3, DATA_BITS=16. The ADC model shifts 0xA5C3 MSB first on SCLK falling edges, with the first bit valid at CS fall.
  - Pulse start -> 16 rising edges, SCLK period 4 cycles; data_out=0xA5C3; data_valid one cycle at cycle 1+2+64+2 = 69.
  - CS low at cycle 1, high at cycle 69.
- Model returns 0xFFFF then 0x0000, start held high continuously:
  - Two frames; CS-high gap ≥3 cycles.
  - data_out 0xFFFF then 0x0000; exactly two valid strobes by cycle 150.
- Extra start pulses at cycles 10, 30, 60 of a frame -> ignored; one data_valid only; busy=1 throughout.
- rst asserted at cycle 40 mid-frame:
  - CS=1, SCLK=0, busy=0 without waiting for a clock edge.
  - data_out stays at its previous value 0x0000 (reset value); no strobe.
  - A new start after release yields a correct 0xA5C3 frame.
- Assertions across all runs:
  - SCLK=0 whenever CS=1.
  - data_valid never high for 2 consecutive cycles.
  - data_out stable except on data_valid.
